// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states, default latencies and latency lookup helpers.
package md_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    // Ops that occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int md_latency(md_op_e op, int mult_cycles, int div_cycles);
        case (op)
            MD_MULT, MD_MULTU: return mult_cycles;
            MD_DIV, MD_DIVU:   return div_cycles;
            default:           return 0;
        endcase
    endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        md_stall;

    modport master (output start, md_op, A, B, input HI, LO, busy, md_stall);
    modport slave  (input start, md_op, A, B, output HI, LO, busy, md_stall);
endinterface

// File: rtl/md_calc.sv
// Combinational 64-bit product and quotient/remainder for MULT/MULTU/DIV/DIVU.
import md_pkg::*;

module md_calc (
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quot;
    logic [31:0] rem;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi        = '0;
        lo        = '0;
        is_signed = (op == MD_MULT) || (op == MD_DIV);
        div_zero  = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);

        // Low 64 bits of the product of sign-extended operands equal the signed product.
        ext_a   = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b   = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        product = ext_a * ext_b;

        // Signed divide runs on magnitudes, then the signs are reapplied (quotient truncates toward zero).
        dvd  = (is_signed && a[31]) ? -a : a;
        dvs  = (is_signed && b[31]) ? -b : b;
        quot = div_zero ? 32'd0 : dvd / dvs;
        rem  = div_zero ? 32'd0 : dvd % dvs;

        if ((op == MD_MULT) || (op == MD_MULTU)) begin
            {hi, lo} = product;
        end else begin
            lo = (is_signed && (a[31] ^ b[31])) ? -quot : quot;
            hi = (is_signed && a[31]) ? -rem : rem;
        end
    end

endmodule

// File: rtl/ex_md_unit.sv
// EX-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO registers
// and a stall output for the hazard unit.
import md_pkg::*;

module ex_md_unit #(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input logic  clk,
    input logic  reset,
    md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q, state_d;
    md_op_e           op;
    logic             launch;
    logic             finish;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      pend_hi_q, pend_lo_q;
    logic             pend_wr_q;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_div_zero;

    assign op = md_op_e'(bus.md_op);

    md_calc u_calc (
        .op       (op),
        .a        (bus.A),
        .b        (bus.B),
        .hi       (calc_hi),
        .lo       (calc_lo),
        .div_zero (calc_div_zero)
    );

    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start && is_long_op(op)) begin
                launch  = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: if (cnt_q == CNT_W'(1)) begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            if (launch) begin
                cnt_q     <= CNT_W'(md_latency(op, MULT_CYCLES, DIV_CYCLES));
                pend_hi_q <= calc_hi;
                pend_lo_q <= calc_lo;
                pend_wr_q <= ~calc_div_zero;
            end else if (state_q == ST_RUN) begin
                cnt_q <= cnt_q - 1'b1;
            end

            // Divide by zero still burns the full busy period but leaves HI/LO alone.
            if (finish && pend_wr_q) begin
                hi_q <= pend_hi_q;
                lo_q <= pend_lo_q;
            end else if ((state_q == ST_IDLE) && bus.start) begin
                if (op == MD_MTHI) hi_q <= bus.A;
                if (op == MD_MTLO) lo_q <= bus.A;
            end
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.md_stall = (state_q == ST_RUN) | (bus.start & is_long_op(op));

endmodule

// File: tb/tb_ex_md_unit.sv
// Self-checking bench for ex_md_unit: directed vectors plus randomized ops
// compared against an arithmetic reference model of HI/LO and busy length.
module tb_ex_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    md_if bus ();

    ex_md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULT_N;
        if (op == 3'd3 || op == 3'd4) return DIV_N;
        return 0;
    endfunction

    // Reference model: architectural effect of one accepted op on HI/LO.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd3: if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic stall);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        #1 stall = bus.md_stall;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        model_op(op, a, b);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
            cycles++;
        end
    endtask

    task automatic test_reset;
        logic st;
        int   cyc;
        #1;
        n_checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_initial: HI=%h LO=%h busy=%b, want 0/0/0", bus.HI, bus.LO, bus.busy);
        end
        @(negedge clk) reset = 1'b1;
        issue(3'd5, 32'hAAAA5555, 32'd0, st);
        issue(3'd6, 32'h5555AAAA, 32'd0, st);
        wait_done(cyc);
        n_checks++;
        if (bus.HI !== m_hi || bus.LO !== m_lo) begin
            n_fail++;
            $display("FAIL mt_before_reset: HI=%h LO=%h, want %h/%h", bus.HI, bus.LO, m_hi, m_lo);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        n_checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: HI=%h LO=%h busy=%b, want 0/0/0", bus.HI, bus.LO, bus.busy);
        end
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: HI=%h LO=%h busy=%b, want 0/0/0", bus.HI, bus.LO, bus.busy);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
        logic [31:0] as  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'hFFFFFFFF};
        logic [31:0] ehi [5] = '{32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'd1, 32'd0};
        logic [31:0] elo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'd3, 32'h80000000};
        logic st;
        int   cyc;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], st);
            wait_done(cyc);
            n_checks++;
            if (st !== 1'b1 || cyc != lat(ops[i])) begin
                n_fail++;
                $display("FAIL directed_%0d_timing: stall=%b busy_cycles=%0d, want 1/%0d", i, st, cyc, lat(ops[i]));
            end
            n_checks++;
            if (bus.HI !== ehi[i] || bus.LO !== elo[i]) begin
                n_fail++;
                $display("FAIL directed_%0d_result: HI=%h LO=%h, want %h/%h", i, bus.HI, bus.LO, ehi[i], elo[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        logic st;
        int   cyc;
        issue(3'd5, 32'h11111111, 32'd0, st);
        n_checks++;
        if (st !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_stall: md_stall=%b, want 0", st);
        end
        issue(3'd6, 32'h22222222, 32'd0, st);
        issue(3'd3, 32'd5, 32'd0, st);
        wait_done(cyc);
        n_checks++;
        if (cyc != DIV_N || bus.HI !== 32'h11111111 || bus.LO !== 32'h22222222) begin
            n_fail++;
            $display("FAIL div_zero: busy_cycles=%0d HI=%h LO=%h, want %0d/11111111/22222222", cyc, bus.HI, bus.LO, DIV_N);
        end
    endtask

    task automatic test_operand_change;
        logic st;
        int   cyc = 0;
        issue(3'd1, 32'd4, 32'd5, st);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cyc++;
            bus.A     = $urandom;
            bus.B     = $urandom;
            bus.start = (cyc == 2);
            bus.md_op = (cyc == 2) ? 3'd6 : 3'd0;
        end
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        n_checks++;
        if (cyc != MULT_N || bus.HI !== 32'd0 || bus.LO !== 32'd20) begin
            n_fail++;
            $display("FAIL operand_change: busy_cycles=%0d HI=%h LO=%h, want %0d/0/20", cyc, bus.HI, bus.LO, MULT_N);
        end
    endtask

    task automatic test_reset_mid_op;
        logic        st;
        int          cyc;
        logic [31:0] a, b;
        issue(3'd5, 32'h00001234, 32'd0, st);
        issue(3'd4, 32'd100, 32'd7, st);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.md_stall !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b stall=%b HI=%h LO=%h, want 0/0/0/0", bus.busy, bus.md_stall, bus.HI, bus.LO);
        end
        @(negedge clk) reset = 1'b1;
        a = $urandom;
        b = $urandom;
        issue(3'd1, a, b, st);
        wait_done(cyc);
        n_checks++;
        if (cyc != MULT_N || bus.HI !== m_hi || bus.LO !== m_lo) begin
            n_fail++;
            $display("FAIL after_reset_mult: busy_cycles=%0d HI=%h LO=%h, want %0d/%h/%h", cyc, bus.HI, bus.LO, MULT_N, m_hi, m_lo);
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        st;
        int          cyc;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'($signed(8'($urandom))) : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 9));
                default: b = $urandom;
            endcase
            issue(op, a, b, st);
            wait_done(cyc);
            n_checks++;
            if (st !== (lat(op) != 0) || cyc != lat(op)) begin
                n_fail++;
                $display("FAIL rand_%0d_timing op=%0d: stall=%b busy_cycles=%0d, want %b/%0d", i, op, st, cyc, lat(op) != 0, lat(op));
            end
            n_checks++;
            if (bus.HI !== m_hi || bus.LO !== m_lo) begin
                n_fail++;
                $display("FAIL rand_%0d_result op=%0d A=%h B=%h: HI=%h LO=%h, want %h/%h", i, op, a, b, bus.HI, bus.LO, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.A     = '0;
        bus.B     = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_operand_change();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
